motor_pwm_driver: RTL and testbench

Downstream stage of the DShot speed handler. Consumes the 8-bit motor speed and an update strobe, and drives a glitch-free PWM output to the motor power stage. It adds arming, limits how fast duty can rise, and forces a failsafe stop when speed updates stop arriving. One instance per motor channel.

---
 rtl/motor_pwm_driver.sv | 95 +++++++++
 tb/tb_motor_pwm_driver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: armed, ramp-limited, timeout-protected PWM drive for one motor channel
// Ports: clk/rst (async active-high); speed_i + speed_update_i strobe in;
// pwm_out_o registered drive, current_duty_o applied duty, armed_o (RUN),
// failsafe_o (FAILSAFE), period_start_o one-cycle pulse after each period boundary.
module motor_pwm_driver #(
  parameter int PRESCALE        = 4,
  parameter int RAMP_STEP       = 8,
  parameter int TIMEOUT_PERIODS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] speed_i,
  input  logic       speed_update_i,
  output logic       pwm_out_o,
  output logic [7:0] current_duty_o,
  output logic       armed_o,
  output logic       failsafe_o,
  output logic       period_start_o
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int TW = $clog2(TIMEOUT_PERIODS + 1);
  typedef enum logic [1:0] {DISARMED, RUN, FAILSAFE} state_e;
  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [7:0]      cnt_q, cnt_d, duty_q, duty_d, target_q, target_d;
  logic [TW-1:0]   to_q, to_d, to_inc;
  logic            pwm_q, ps_q, armed_q, fs_q;
  logic            tick, boundary;
  logic [8:0]      diff, step;
  always_comb begin
    tick     = pre_q == PW'(PRESCALE - 1);
    boundary = tick && cnt_q == 8'hff;
    pre_d    = tick ? '0 : pre_q + PW'(1);
    cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
    diff     = {1'b0, target_q} - {1'b0, duty_q};
    step     = diff > 9'(RAMP_STEP) ? 9'(RAMP_STEP) : diff;
    to_inc   = to_q + TW'(1);
    state_d  = state_q;
    target_d = target_q;
    duty_d   = duty_q;
    to_d     = to_q;
    if (state_q != RUN) begin
      target_d = '0;
      duty_d   = '0;
      to_d     = '0;
      if (speed_update_i && speed_i == '0) state_d = RUN;
    end else begin
      // ramp uses the target held before this edge; a same-edge update lands next period
      if (boundary) duty_d = target_q > duty_q ? duty_q + step[7:0] : target_q;
      if (speed_update_i) begin
        target_d = speed_i;
        to_d     = '0;
      end else if (boundary) begin
        if (to_inc == TW'(TIMEOUT_PERIODS)) begin
          state_d  = FAILSAFE;
          duty_d   = '0;
          target_d = '0;
          to_d     = '0;
        end else begin
          to_d = to_inc;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DISARMED;
      pre_q    <= '0;
      cnt_q    <= '0;
      duty_q   <= '0;
      target_q <= '0;
      to_q     <= '0;
      pwm_q    <= 1'b0;
      ps_q     <= 1'b0;
      armed_q  <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      to_q     <= to_d;
      pwm_q    <= state_q == RUN && cnt_q < duty_q;
      ps_q     <= boundary;
      armed_q  <= state_d == RUN;
      fs_q     <= state_d == FAILSAFE;
    end
  end
  assign pwm_out_o      = pwm_q;
  assign current_duty_o = duty_q;
  assign armed_o        = armed_q;
  assign failsafe_o     = fs_q;
  assign period_start_o = ps_q;
endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: scenario tasks with a duty scoreboard for motor_pwm_driver
module tb_motor_pwm_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] speed_i = '0;
  logic       speed_update_i = 1'b0;
  logic       pwm_out_o, armed_o, failsafe_o, period_start_o;
  logic [7:0] current_duty_o;
  int         pass_cnt = 0;
  int         total = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  motor_pwm_driver #(.PRESCALE(1), .RAMP_STEP(16), .TIMEOUT_PERIODS(4)) dut (
    .clk(clk), .rst(rst), .speed_i(speed_i), .speed_update_i(speed_update_i),
    .pwm_out_o(pwm_out_o), .current_duty_o(current_duty_o), .armed_o(armed_o),
    .failsafe_o(failsafe_o), .period_start_o(period_start_o)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic upd(input logic [7:0] v);
    speed_i = v;
    speed_update_i = 1'b1;
    @(posedge clk);
    #1;
    speed_update_i = 1'b0;
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!period_start_o && n < 600);
    if (!period_start_o) begin
      total++;
      $display("FAIL wait_period_start: none within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    tick(3);
    total++; if (pwm_out_o !== 1'b0) $display("FAIL reset_pwm: got %b want 0", pwm_out_o); else pass_cnt++;
    total++; if (current_duty_o !== 8'd0) $display("FAIL reset_duty: got %0d want 0", current_duty_o); else pass_cnt++;
    total++; if (armed_o !== 1'b0) $display("FAIL reset_armed: got %b want 0", armed_o); else pass_cnt++;
    total++; if (failsafe_o !== 1'b0) $display("FAIL reset_failsafe: got %b want 0", failsafe_o); else pass_cnt++;
    total++; if (period_start_o !== 1'b0) $display("FAIL reset_period_start: got %b want 0", period_start_o); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_arming();
    int n;
    wait_ps(n);
    wait_ps(n);
    total++; if (n !== 256) $display("FAIL period_len: got %0d want 256", n); else pass_cnt++;
    upd(8'd100);
    tick(2);
    total++; if (armed_o !== 1'b0) $display("FAIL arm_ignore_nonzero: got %b want 0", armed_o); else pass_cnt++;
    total++; if (pwm_out_o !== 1'b0) $display("FAIL arm_pwm_low: got %b want 0", pwm_out_o); else pass_cnt++;
    upd(8'd0);
    total++; if (armed_o !== 1'b1) $display("FAIL arm_zero: got %b want 1", armed_o); else pass_cnt++;
    total++; if (current_duty_o !== 8'd0) $display("FAIL arm_duty: got %0d want 0", current_duty_o); else pass_cnt++;
  endtask

  task automatic test_ramp();
    int n, hi;
    logic [7:0] e;
    upd(8'd64);
    exp_q.push_back(8'd16); exp_q.push_back(8'd32); exp_q.push_back(8'd48); exp_q.push_back(8'd64);
    wait_ps(n);
    e = exp_q.pop_front();
    total++; if (current_duty_o !== e) $display("FAIL ramp_duty: got %0d want %0d", current_duty_o, e); else pass_cnt++;
    hi = 0;
    speed_i = 8'd64;
    for (int k = 0; k < 256; k++) begin
      if (pwm_out_o) hi++;
      speed_update_i = (k == 100);
      @(posedge clk);
      #1;
    end
    speed_update_i = 1'b0;
    total++; if (hi !== 16) $display("FAIL ramp_high_cycles: got %0d want 16", hi); else pass_cnt++;
    e = exp_q.pop_front();
    total++; if (current_duty_o !== e) $display("FAIL ramp_duty: got %0d want %0d", current_duty_o, e); else pass_cnt++;
    repeat (2) begin
      tick(100);
      upd(8'd64);
      wait_ps(n);
      e = exp_q.pop_front();
      total++; if (current_duty_o !== e) $display("FAIL ramp_duty: got %0d want %0d", current_duty_o, e); else pass_cnt++;
    end
  endtask

  task automatic test_decrease();
    int n;
    logic [7:0] e;
    tick(100);
    upd(8'd10);
    exp_q.push_back(8'd10);
    total++; if (current_duty_o !== 8'd64) $display("FAIL decrease_hold: got %0d want 64", current_duty_o); else pass_cnt++;
    wait_ps(n);
    e = exp_q.pop_front();
    total++; if (current_duty_o !== e) $display("FAIL decrease_duty: got %0d want %0d", current_duty_o, e); else pass_cnt++;
  endtask

  task automatic test_failsafe();
    int n;
    logic [7:0] e;
    tick(100);
    upd(8'd48);
    exp_q.push_back(8'd26); exp_q.push_back(8'd42); exp_q.push_back(8'd48);
    repeat (3) begin
      wait_ps(n);
      e = exp_q.pop_front();
      total++; if (current_duty_o !== e) $display("FAIL fs_ramp_duty: got %0d want %0d", current_duty_o, e); else pass_cnt++;
    end
    wait_ps(n);
    total++; if (failsafe_o !== 1'b1) $display("FAIL fs_flag: got %b want 1", failsafe_o); else pass_cnt++;
    total++; if (armed_o !== 1'b0) $display("FAIL fs_armed: got %b want 0", armed_o); else pass_cnt++;
    total++; if (current_duty_o !== 8'd0) $display("FAIL fs_duty: got %0d want 0", current_duty_o); else pass_cnt++;
    tick(1);
    total++; if (pwm_out_o !== 1'b0) $display("FAIL fs_pwm: got %b want 0", pwm_out_o); else pass_cnt++;
    upd(8'd50);
    tick(1);
    total++; if (failsafe_o !== 1'b1 || armed_o !== 1'b0) $display("FAIL fs_ignore_nonzero: got fs=%b armed=%b want fs=1 armed=0", failsafe_o, armed_o); else pass_cnt++;
    upd(8'd0);
    total++; if (failsafe_o !== 1'b0 || armed_o !== 1'b1) $display("FAIL fs_rearm: got fs=%b armed=%b want fs=0 armed=1", failsafe_o, armed_o); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int n;
    logic [7:0] e;
    repeat (3) begin
      exp_q.push_back(8'd0);
      wait_ps(n);
      e = exp_q.pop_front();
      total++; if (current_duty_o !== e) $display("FAIL sim_idle_duty: got %0d want %0d", current_duty_o, e); else pass_cnt++;
    end
    tick(255);
    exp_q.push_back(8'd0);
    upd(8'd32);
    total++; if (period_start_o !== 1'b1) $display("FAIL sim_aligned: got %b want 1", period_start_o); else pass_cnt++;
    total++; if (failsafe_o !== 1'b0 || armed_o !== 1'b1) $display("FAIL sim_timeout_race: got fs=%b armed=%b want fs=0 armed=1", failsafe_o, armed_o); else pass_cnt++;
    e = exp_q.pop_front();
    total++; if (current_duty_o !== e) $display("FAIL sim_old_target: got %0d want %0d", current_duty_o, e); else pass_cnt++;
    exp_q.push_back(8'd16); exp_q.push_back(8'd32);
    repeat (2) begin
      wait_ps(n);
      e = exp_q.pop_front();
      total++; if (current_duty_o !== e) $display("FAIL sim_ramp: got %0d want %0d", current_duty_o, e); else pass_cnt++;
    end
    tick(255);
    exp_q.push_back(8'd32);
    upd(8'd200);
    e = exp_q.pop_front();
    total++; if (current_duty_o !== e) $display("FAIL sim_boundary_update: got %0d want %0d", current_duty_o, e); else pass_cnt++;
    exp_q.push_back(8'd48);
    wait_ps(n);
    e = exp_q.pop_front();
    total++; if (current_duty_o !== e) $display("FAIL sim_new_target: got %0d want %0d", current_duty_o, e); else pass_cnt++;
    total++; if (failsafe_o !== 1'b0) $display("FAIL sim_no_failsafe: got %b want 0", failsafe_o); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int n;
    logic [7:0] e;
    for (int i = 0; i < 5; i++) begin
      tick(50);
      upd(8'd128);
      exp_q.push_back(8'(64 + 16 * i));
      wait_ps(n);
      e = exp_q.pop_front();
      total++; if (current_duty_o !== e) $display("FAIL ar_ramp: got %0d want %0d", current_duty_o, e); else pass_cnt++;
    end
    tick(10);
    total++; if (pwm_out_o !== 1'b1) $display("FAIL ar_pwm_high: got %b want 1", pwm_out_o); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total++; if (pwm_out_o !== 1'b0) $display("FAIL ar_pwm_drop: got %b want 0", pwm_out_o); else pass_cnt++;
    total++; if (current_duty_o !== 8'd0) $display("FAIL ar_duty: got %0d want 0", current_duty_o); else pass_cnt++;
    total++; if (armed_o !== 1'b0) $display("FAIL ar_armed: got %b want 0", armed_o); else pass_cnt++;
    tick(2);
    rst = 1'b0;
    tick(1);
    total++; if (armed_o !== 1'b0 || failsafe_o !== 1'b0) $display("FAIL ar_after_release: got armed=%b fs=%b want 0 0", armed_o, failsafe_o); else pass_cnt++;
    upd(8'd100);
    tick(1);
    total++; if (armed_o !== 1'b0) $display("FAIL ar_disarmed_ignore: got %b want 0", armed_o); else pass_cnt++;
    upd(8'd0);
    total++; if (armed_o !== 1'b1) $display("FAIL ar_rearm: got %b want 1", armed_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_arming();
    test_ramp();
    test_decrease();
    test_failsafe();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
